// File: rtl/filt_cic_interp.sv
// rtl/filt_cic_interp.sv - CIC interpolator: N combs at the low rate, zero-stuff by R, N integrators, unity-gain output
module filt_cic_interp #(
  parameter int DATA_WIDTH = 16,
  parameter int RATE_POWER = 2,
  parameter int NUM_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  underflow
);

  localparam int W = DATA_WIDTH + NUM_STAGES * RATE_POWER;
  localparam int S = (NUM_STAGES - 1) * RATE_POWER;
  localparam logic signed [W-1:0] SAT_HI = {{(W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_LO = {{(W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [RATE_POWER-1:0]  phase;
  logic signed [W-1:0]    held;
  logic signed [W-1:0]    data_ext;
  logic signed [W-1:0]    comb_out;
  logic signed [W-1:0]    zin;
  logic signed [W-1:0]    comb_dly [NUM_STAGES];
  logic signed [W-1:0]    comb_tap [NUM_STAGES+1];
  logic signed [W-1:0]    integ    [NUM_STAGES];
  logic signed [W-1:0]    last;
  logic        [W-1:0]    mag;
  logic        [W-1:0]    shifted;
  logic signed [W-1:0]    scaled;
  logic [DATA_WIDTH-1:0]  sat_val;
  logic                   accept;
  logic                   miss;

  assign in_ready = (phase == '0);
  assign accept   = ena & in_ready & in_valid;
  assign miss     = ena & in_ready & ~in_valid;
  assign data_ext = {{(W-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};

  // A missing sample repeats the held value so the comb sees a flat input, not a spike to zero.
  always_comb begin
    comb_tap[0] = in_valid ? data_ext : held;
    for (int k = 0; k < NUM_STAGES; k++) begin
      comb_tap[k+1] = comb_tap[k] - comb_dly[k];
    end
  end

  // comb_out is refreshed on phase 0, so phase 1 is the one slot that carries it.
  assign zin = (phase == RATE_POWER'(1)) ? comb_out : '0;

  // Symmetric truncation: shift the magnitude so negative values round toward zero too.
  always_comb begin
    last    = integ[NUM_STAGES-1];
    mag     = last[W-1] ? -last : last;
    shifted = mag >> S;
    scaled  = last[W-1] ? -$signed(shifted) : $signed(shifted);
    if (scaled > SAT_HI) begin
      sat_val = SAT_HI[DATA_WIDTH-1:0];
    end else if (scaled < SAT_LO) begin
      sat_val = SAT_LO[DATA_WIDTH-1:0];
    end else begin
      sat_val = scaled[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      held      <= '0;
      comb_out  <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      underflow <= 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        comb_dly[k] <= '0;
        integ[k]    <= '0;
      end
    end else begin
      out_valid <= ena;
      if (ena) begin
        phase <= phase + 1'b1;
        if (accept) begin
          held <= data_ext;
        end
        if (miss) begin
          underflow <= 1'b1;
        end
        if (in_ready) begin
          for (int k = 0; k < NUM_STAGES; k++) begin
            comb_dly[k] <= comb_tap[k];
          end
          comb_out <= comb_tap[NUM_STAGES];
        end
        // Integrators wrap modulo 2**W; the comb differences cancel the wrap at the output.
        integ[0] <= integ[0] + zin;
        for (int k = 1; k < NUM_STAGES; k++) begin
          integ[k] <= integ[k] + integ[k-1];
        end
        data_out <= sat_val;
      end
    end
  end

endmodule
